// File: rtl/pwm_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_audio_pkg
// Description : Shared audio-path types, constants and sample scaling.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_audio_pkg;

    localparam int SAMPLE_W = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    localparam sample_t MIDSCALE = sample_t'(1 << (SAMPLE_W - 1));

    // Centre the offset-binary sample, attenuate by an arithmetic shift and re-offset.
    function automatic sample_t scale(input sample_t x, input logic [1:0] vol);
        logic signed [SAMPLE_W-1:0] w_centred;
        logic signed [SAMPLE_W-1:0] w_atten;
        w_centred = signed'(x - MIDSCALE);
        w_atten   = w_centred >>> vol;
        return sample_t'(w_atten) + MIDSCALE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous sample FIFO with level output, no write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_lw = $clog2(DEPTH) + 1;
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
    localparam logic [c_lw-1:0] c_lvl_one = c_lw'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_lw-1:0]  r_level;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_level == c_lw'(DEPTH));
    assign w_empty   = (r_level == '0);
    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + c_lvl_one;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - c_lvl_one;
            end
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_level    = r_level;

endmodule
`default_nettype wire

// File: rtl/pwm_sample_dac.sv
`default_nettype none
// ============================================================================
// Module      : pwm_sample_dac
// Description : Buffered audio sample playout as a glitch-free PWM duty cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_sample_dac #(
    parameter int SAMPLE_W           = 8,
    parameter int FIFO_DEPTH         = 4,
    parameter int PERIODS_PER_SAMPLE = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [1:0]                    volume,
    input  logic [SAMPLE_W-1:0]           s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          underrun_clr,
    output logic                          pwm,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          sample_tick
);

    import pwm_audio_pkg::*;

    localparam int c_period_w = (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;
    localparam logic [c_period_w-1:0] c_last_period = c_period_w'(PERIODS_PER_SAMPLE - 1);
    localparam logic [c_period_w-1:0] c_period_one  = c_period_w'(1);
    localparam logic [SAMPLE_W-1:0]   c_cnt_one     = SAMPLE_W'(1);

    logic [SAMPLE_W-1:0]          r_cnt;
    logic [c_period_w-1:0]        r_period;
    sample_t                      r_cur_sample;
    sample_t                      r_duty;
    logic                         r_pwm;
    logic                         r_underrun;
    logic                         r_sample_tick;

    logic                         w_wrap;
    logic                         w_boundary;
    logic                         w_push;
    logic                         w_fifo_full;
    logic                         w_fifo_empty;
    sample_t                      w_head;
    logic [$clog2(FIFO_DEPTH):0]  w_level;

    assign w_wrap     = enable && (r_cnt == '1);
    assign w_boundary = w_wrap && (r_period == c_last_period);
    assign w_push     = s_valid && !w_fifo_full;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (s_data),
        .i_pop       (w_boundary),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_level     (w_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_period      <= '0;
            r_cur_sample  <= MIDSCALE;
            r_duty        <= MIDSCALE;
            r_pwm         <= 1'b0;
            r_underrun    <= 1'b0;
            r_sample_tick <= 1'b0;
        end else begin
            r_pwm         <= enable && (r_cnt < r_duty);
            r_sample_tick <= w_boundary;

            if (enable) begin
                r_cnt <= r_cnt + c_cnt_one;
            end else begin
                r_cnt <= '0;
            end

            // Duty only moves on the wrap cycle so a period is never cut mid-way.
            if (w_wrap) begin
                if (w_boundary) begin
                    r_period <= '0;
                end else begin
                    r_period <= r_period + c_period_one;
                end
                if (w_boundary && !w_fifo_empty) begin
                    r_cur_sample <= w_head;
                    r_duty       <= scale(w_head, volume);
                end else begin
                    r_duty       <= scale(r_cur_sample, volume);
                end
            end

            if (w_boundary && w_fifo_empty) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign s_ready     = !w_fifo_full;
    assign pwm         = r_pwm;
    assign underrun    = r_underrun;
    assign level       = w_level;
    assign sample_tick = r_sample_tick;

endmodule
`default_nettype wire
